// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared constants and state encoding for the imem loader
package imem_loader_pkg;

  // Frame start marker default
  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  // Frame layout: bytes per instruction word, default word-count width
  localparam int BYTES_PER_WORD = 4;
  localparam int LEN_W_DEFAULT  = 16;

  // Instruction memory write-port geometry
  localparam int IMEM_DATA_W         = 32;
  localparam int IMEM_ADDR_W_DEFAULT = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_LO,
    ST_LEN_HI,
    ST_DATA,
    ST_CSUM,
    ST_DONE
  } state_t;

endpackage

// File: rtl/imem_byte_packer.sv
// rtl/imem_byte_packer.sv - collects four stream bytes into a little-endian 32-bit word
module imem_byte_packer
  import imem_loader_pkg::*;
(
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_clear,
  input  logic                   i_byte_valid,
  input  logic [7:0]             i_byte,
  output logic                   o_last_byte,
  output logic                   o_word_ready,
  output logic [IMEM_DATA_W-1:0] o_word
);

  localparam int CNT_W = $clog2(BYTES_PER_WORD);

  logic [CNT_W-1:0]       r_cnt;
  logic [IMEM_DATA_W-1:0] r_word;
  logic                   r_word_ready;

  // The byte about to be taken completes the current word
  assign o_last_byte  = (r_cnt == CNT_W'(BYTES_PER_WORD - 1));
  assign o_word_ready = r_word_ready;
  assign o_word       = r_word;

  // Shift bytes in from the top so the first byte lands in bits [7:0]
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt        <= '0;
      r_word       <= '0;
      r_word_ready <= 1'b0;
    end else begin
      r_word_ready <= i_byte_valid && o_last_byte;
      if (i_clear) begin
        r_cnt <= '0;
      end else if (i_byte_valid) begin
        r_cnt  <= r_cnt + CNT_W'(1);
        r_word <= {i_byte, r_word[IMEM_DATA_W-1:8]};
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - framed byte stream to instruction memory writer with XOR checksum
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int         ADDR_W    = IMEM_ADDR_W_DEFAULT,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT,
  parameter int         LEN_W     = LEN_W_DEFAULT
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [7:0]             i_in_data,
  input  logic                   i_in_valid,
  output logic                   o_in_ready,
  output logic                   o_imem_we,
  output logic [ADDR_W-1:0]      o_imem_addr,
  output logic [IMEM_DATA_W-1:0] o_imem_wdata,
  output logic                   o_cpu_hold,
  output logic                   o_load_done,
  output logic                   o_load_err
);

  state_t            r_state;
  state_t            w_next;
  logic              r_in_ready;
  logic              r_cpu_hold;
  logic              r_load_done;
  logic              r_load_err;
  logic [7:0]        r_len_lo;
  logic [7:0]        r_xor_acc;
  logic [LEN_W-1:0]  r_words_left;
  logic [ADDR_W-1:0] r_word_idx;
  logic [ADDR_W-1:0] r_imem_addr;

  logic             w_accept;
  logic             w_start;
  logic             w_len_lo_byte;
  logic             w_len_hi_byte;
  logic             w_data_byte;
  logic             w_csum_byte;
  logic             w_last_byte;
  logic             w_word_ready;
  logic [LEN_W-1:0] w_len;
  logic [IMEM_DATA_W-1:0] w_word;

  assign w_accept = i_in_valid && r_in_ready;
  assign w_len    = LEN_W'({i_in_data, r_len_lo});

  imem_byte_packer u_packer (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_clear      (w_start),
    .i_byte_valid (w_data_byte),
    .i_byte       (i_in_data),
    .o_last_byte  (w_last_byte),
    .o_word_ready (w_word_ready),
    .o_word       (w_word)
  );

  // Next-state decode and per-byte role strobes
  always_comb begin
    w_next        = r_state;
    w_start       = 1'b0;
    w_len_lo_byte = 1'b0;
    w_len_hi_byte = 1'b0;
    w_data_byte   = 1'b0;
    w_csum_byte   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && (i_in_data == SYNC_BYTE)) begin
          w_start = 1'b1;
          w_next  = ST_LEN_LO;
        end
      end
      ST_LEN_LO: begin
        if (w_accept) begin
          w_len_lo_byte = 1'b1;
          w_next        = ST_LEN_HI;
        end
      end
      ST_LEN_HI: begin
        if (w_accept) begin
          w_len_hi_byte = 1'b1;
          w_next        = (w_len == '0) ? ST_CSUM : ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_accept) begin
          w_data_byte = 1'b1;
          if (w_last_byte && (r_words_left == LEN_W'(1))) begin
            w_next = ST_CSUM;
          end
        end
      end
      ST_CSUM: begin
        if (w_accept) begin
          w_csum_byte = 1'b1;
          w_next      = ST_DONE;
        end
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // State, registered outputs, counters and checksum accumulator
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= ST_IDLE;
      r_in_ready   <= 1'b0;
      r_cpu_hold   <= 1'b0;
      r_load_done  <= 1'b0;
      r_load_err   <= 1'b0;
      r_len_lo     <= '0;
      r_xor_acc    <= '0;
      r_words_left <= '0;
      r_word_idx   <= '0;
      r_imem_addr  <= '0;
    end else begin
      r_state     <= w_next;
      r_in_ready  <= (w_next != ST_DONE);
      r_cpu_hold  <= (w_next != ST_IDLE);
      r_load_done <= (w_next == ST_DONE);
      if (w_start) begin
        r_load_err <= 1'b0;
        r_word_idx <= '0;
        r_xor_acc  <= '0;
      end
      if (w_len_lo_byte) begin
        r_len_lo <= i_in_data;
      end
      if (w_len_hi_byte) begin
        r_words_left <= w_len;
      end
      if (w_data_byte) begin
        r_xor_acc <= r_xor_acc ^ i_in_data;
        if (w_last_byte) begin
          r_imem_addr  <= r_word_idx;
          r_word_idx   <= r_word_idx + ADDR_W'(1);
          r_words_left <= r_words_left - LEN_W'(1);
        end
      end
      if (w_csum_byte) begin
        r_load_err <= (i_in_data != r_xor_acc);
      end
    end
  end

  assign o_in_ready   = r_in_ready;
  assign o_imem_we    = w_word_ready;
  assign o_imem_addr  = r_imem_addr;
  assign o_imem_wdata = w_word;
  assign o_cpu_hold   = r_cpu_hold;
  assign o_load_done  = r_load_done;
  assign o_load_err   = r_load_err;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - randomized frame bench with a word-list memory model
module tb_imem_loader;

  localparam int AW    = 5;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_hold;
  logic          load_done;
  logic          load_err;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int ready_viol = 0;
  int rcnt = 0;

  logic [31:0]   exp_mem [DEPTH];
  logic [31:0]   mon_mem [DEPTH];
  logic [31:0]   fw [64];
  logic [AW-1:0] wq_addr [$];
  logic [31:0]   wq_data [$];

  always #5 clk = ~clk;

  imem_loader dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_in_data    (in_data),
    .i_in_valid   (in_valid),
    .o_in_ready   (in_ready),
    .o_imem_we    (imem_we),
    .o_imem_addr  (imem_addr),
    .o_imem_wdata (imem_wdata),
    .o_cpu_hold   (cpu_hold),
    .o_load_done  (load_done),
    .o_load_err   (load_err)
  );

  // Observe the write port and status between clock edges
  always @(negedge clk) begin
    if (imem_we) begin
      mon_mem[imem_addr] = imem_wdata;
      wq_addr.push_back(imem_addr);
      wq_data.push_back(imem_wdata);
    end
    if (load_done) done_cnt++;
    if (!rst_n) rcnt = 0;
    else if (rcnt < 3) rcnt++;
    if (rcnt >= 2 && (in_ready !== !load_done)) ready_viol++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    bit ok;
    if (gaps) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    in_data  = b;
    in_valid = 1'b1;
    ok       = 1'b0;
    for (int t = 0; t < 200 && !ok; t++) begin
      if (in_ready) begin
        @(posedge clk);
        ok = 1'b1;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (!ok) chk("byte_timeout", 32'(ok), 32'd1);
  endtask

  task automatic send_frame(input int n, input bit bad, input bit gaps);
    logic [7:0]  cs;
    logic [31:0] w;
    cs = 8'h00;
    wq_addr.delete();
    wq_data.delete();
    send_byte(8'hA5, gaps);
    chk("sync_clears_err", 32'(load_err), 32'd0);
    chk("sync_sets_hold", 32'(cpu_hold), 32'd1);
    send_byte(n[7:0], gaps);
    send_byte(n[15:8], gaps);
    for (int i = 0; i < n; i++) begin
      w = fw[i];
      for (int k = 0; k < 4; k++) begin
        cs = cs ^ w[7:0];
        send_byte(w[7:0], gaps);
        w = w >> 8;
      end
      exp_mem[i % DEPTH] = fw[i];
    end
    send_byte(bad ? (cs ^ 8'h01) : cs, gaps);
  endtask

  task automatic check_frame(input string tag, input int n, input bit bad, input int done_before);
    int mism;
    bit seen;
    seen = 1'b0;
    for (int t = 0; t < 50 && !seen; t++) begin
      @(negedge clk);
      seen = (done_cnt > done_before);
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    chk({tag, "_load_err"}, 32'(load_err), 32'(bad));
    chk({tag, "_write_count"}, 32'(wq_addr.size()), 32'(n));
    for (int i = 0; i < n && i < wq_addr.size(); i++) begin
      chk({tag, "_waddr"}, 32'(wq_addr[i]), 32'(i % DEPTH));
      chk({tag, "_wdata"}, wq_data[i], fw[i]);
    end
    mism = 0;
    for (int a = 0; a < DEPTH; a++) if (mon_mem[a] !== exp_mem[a]) mism++;
    chk({tag, "_mem_image"}, 32'(mism), 32'd0);
    @(negedge clk);
    chk({tag, "_hold_released"}, 32'(cpu_hold), 32'd0);
    chk({tag, "_single_done"}, 32'(done_cnt), 32'(done_before + 1));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_we"}, 32'(imem_we), 32'd0);
    chk({tag, "_hold"}, 32'(cpu_hold), 32'd0);
    chk({tag, "_done"}, 32'(load_done), 32'd0);
    chk({tag, "_err"}, 32'(load_err), 32'd0);
  endtask

  initial begin
    int d;
    logic [31:0] w;
    for (int a = 0; a < DEPTH; a++) begin
      exp_mem[a] = 32'h0;
      mon_mem[a] = 32'h0;
    end
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    chk("reset_addr", 32'(imem_addr), 32'd0);
    chk("reset_wdata", imem_wdata, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("ready_after_reset", 32'(in_ready), 32'd1);

    // Two-instruction frame with correct checksum
    fw[0] = 32'h00000013;
    fw[1] = 32'h00100093;
    d = done_cnt;
    send_frame(2, 1'b0, 1'b0);
    check_frame("t1", 2, 1'b0, d);

    // Same frame, corrupted checksum: words still land, error flagged
    d = done_cnt;
    send_frame(2, 1'b1, 1'b0);
    check_frame("t2", 2, 1'b1, d);
    for (int i = 0; i < 3; i++) fw[i] = $urandom;
    d = done_cnt;
    send_frame(3, 1'b0, 1'b0);
    check_frame("t2b", 3, 1'b0, d);

    // Junk before SYNC is dropped, then an empty frame
    wq_addr.delete();
    wq_data.delete();
    send_byte(8'h00, 1'b0);
    send_byte(8'hFF, 1'b0);
    send_byte(8'h5A, 1'b0);
    chk("junk_no_hold", 32'(cpu_hold), 32'd0);
    chk("junk_no_write", 32'(wq_addr.size()), 32'd0);
    d = done_cnt;
    send_frame(0, 1'b0, 1'b0);
    check_frame("t3", 0, 1'b0, d);

    // More words than memory depth: addresses wrap
    for (int i = 0; i < 33; i++) fw[i] = $urandom;
    d = done_cnt;
    send_frame(33, 1'b0, 1'b1);
    check_frame("t4", 33, 1'b0, d);

    // Asynchronous reset part way through the second word
    for (int i = 0; i < 4; i++) fw[i] = $urandom;
    wq_addr.delete();
    wq_data.delete();
    d = done_cnt;
    send_byte(8'hA5, 1'b0);
    send_byte(8'h04, 1'b0);
    send_byte(8'h00, 1'b0);
    for (int i = 0; i < 2; i++) begin
      w = fw[i];
      for (int k = 0; k < ((i == 0) ? 4 : 2); k++) begin
        send_byte(w[7:0], 1'b0);
        w = w >> 8;
      end
    end
    rst_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    exp_mem[0] = fw[0];
    chk("midreset_writes", 32'(wq_addr.size()), 32'd1);
    chk("midreset_word0", mon_mem[0], fw[0]);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("midreset_no_done", 32'(done_cnt), 32'(d));
    for (int i = 0; i < 5; i++) fw[i] = $urandom;
    d = done_cnt;
    send_frame(5, 1'b0, 1'b0);
    check_frame("t5", 5, 1'b0, d);

    // First frame again with random valid gaps
    fw[0] = 32'h00000013;
    fw[1] = 32'h00100093;
    d = done_cnt;
    send_frame(2, 1'b0, 1'b1);
    check_frame("t6", 2, 1'b0, d);

    chk("ready_only_low_in_done", 32'(ready_viol), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
